vvp_seq_ctrl: RTL and testbench

- Sequencer for one N-wide vvp dot-product unit.
- Streams a job of (LEN) chunks × (PLANES) data bit-planes through the vvp by generating weight/data memory read addresses.
- Weights tag each returning vvp result with its plane index; accumulates plane-shifted, sign-extended results into one wide dot product.
- Presents the result on a valid/ready handshake.
- W/D buses go memory→vvp directly; this block drives only addresses, mode and control.

---
 rtl/vvp_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_vvp_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vvp_seq_ctrl.sv
// vvp_seq_ctrl: issues W/D read addresses for a chunks x bit-planes job and accumulates plane-weighted vvp results.
// Optional macro VVP_SEQ_CTRL_SAT_EN: saturating accumulation plus sticky res_ovf output.
module vvp_seq_ctrl #(
   parameter int N       = 64,
   parameter int AW      = 10,
   parameter int LW      = 8,
   parameter int PW      = 3,
   parameter int RDLAT   = 1,
   parameter int VVP_LAT = 0,
   parameter int ACCW    = 32,
   localparam int SW     = $clog2(N) + 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [1:0]             cfg_mode,
   input  logic [AW-1:0]          cfg_base,
   input  logic [LW-1:0]          cfg_len,
   input  logic [PW-1:0]          cfg_planes,
   output logic                   busy,
   output logic                   mem_re,
   output logic [AW-1:0]          mem_addr,
   output logic [1:0]             vvp_mode,
   input  logic signed [SW-1:0]   vvp_S,
   output logic signed [ACCW-1:0] res,
   output logic                   res_valid,
`ifdef VVP_SEQ_CTRL_SAT_EN
   output logic                   res_ovf,
`endif
   input  logic                   res_ready
);

   localparam int D = RDLAT + VVP_LAT;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                 r_state, w_nextState;
   logic [AW-1:0]          r_addr;
   logic [LW-1:0]          r_len, r_c;
   logic [PW-1:0]          r_planes, r_p;
   logic [1:0]             r_mode;
   logic                   r_busy;
   logic                   r_resValid;
   logic signed [ACCW-1:0] r_acc, r_res, w_accNext;
   logic [D-1:0]           r_tagV;
   logic [PW-1:0]          r_tagP [D];
   logic                   w_issue, w_lastIssue, w_upV, w_finish, w_tagOutV;
   logic [PW-1:0]          w_tagOutP;

   assign w_issue     = (r_state == S_ISSUE);
   assign w_lastIssue = w_issue && (r_c == r_len) && (r_p == r_planes);
   assign w_tagOutV   = r_tagV[D-1];
   assign w_tagOutP   = r_tagP[D-1];

   // Any tag still upstream of the output stage means more results are coming.
   always_comb begin
      w_upV = 1'b0;
      for (int i = 0; i < D - 1; i++) w_upV = w_upV | r_tagV[i];
   end

   assign w_finish = (r_state == S_DRAIN) && !w_upV;

`ifdef VVP_SEQ_CTRL_SAT_EN
   localparam int EW = ACCW + (1 << PW) + 1;
   localparam logic signed [EW-1:0] MAXV = (EW'(1) << (ACCW - 1)) - EW'(1);
   localparam logic signed [EW-1:0] MINV = -(EW'(1) << (ACCW - 1));

   logic signed [EW-1:0] w_term, w_sum;
   logic                 w_sat, r_ovf, r_resOvf, w_ovfNext;

   always_comb begin
      w_term    = EW'(vvp_S) <<< w_tagOutP;
      w_sum     = EW'(r_acc) + w_term;
      w_sat     = 1'b0;
      w_accNext = r_acc;
      if (w_tagOutV) begin
         if (w_sum > MAXV) begin
            w_accNext = MAXV[ACCW-1:0];
            w_sat     = 1'b1;
         end else if (w_sum < MINV) begin
            w_accNext = MINV[ACCW-1:0];
            w_sat     = 1'b1;
         end else begin
            w_accNext = w_sum[ACCW-1:0];
         end
      end
   end

   assign w_ovfNext = r_ovf | w_sat;
   assign res_ovf   = r_resOvf;
`else
   logic signed [ACCW-1:0] w_term;

   always_comb begin
      w_term    = ACCW'(vvp_S) <<< w_tagOutP;
      w_accNext = w_tagOutV ? (r_acc + w_term) : r_acc;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (start) w_nextState = S_ISSUE;
         S_ISSUE: if (w_lastIssue) w_nextState = S_DRAIN;
         S_DRAIN: if (w_finish) w_nextState = S_DONE;
         S_DONE:  if (r_resValid && res_ready) w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Tag pipe mirrors memory + vvp latency so each result meets its plane index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tagV <= '0;
         for (int i = 0; i < D; i++) r_tagP[i] <= '0;
      end else begin
         r_tagV[0] <= w_issue;
         r_tagP[0] <= r_p;
         for (int i = 1; i < D; i++) begin
            r_tagV[i] <= r_tagV[i-1];
            r_tagP[i] <= r_tagP[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr     <= '0;
         r_len      <= '0;
         r_planes   <= '0;
         r_c        <= '0;
         r_p        <= '0;
         r_mode     <= '0;
         r_busy     <= 1'b0;
         r_acc      <= '0;
         r_res      <= '0;
         r_resValid <= 1'b0;
`ifdef VVP_SEQ_CTRL_SAT_EN
         r_ovf      <= 1'b0;
         r_resOvf   <= 1'b0;
`endif
      end else begin
         if (r_state == S_IDLE && start) begin
            r_addr   <= cfg_base;
            r_len    <= cfg_len;
            r_planes <= cfg_planes;
            r_c      <= '0;
            r_p      <= '0;
            r_mode   <= cfg_mode;
            r_busy   <= 1'b1;
            r_acc    <= '0;
`ifdef VVP_SEQ_CTRL_SAT_EN
            r_ovf    <= 1'b0;
`endif
         end else begin
            r_acc <= w_accNext;
`ifdef VVP_SEQ_CTRL_SAT_EN
            r_ovf <= w_ovfNext;
`endif
         end
         // Issue order is linear, so a running address equals base + c*(planes+1) + p.
         if (w_issue) begin
            r_addr <= r_addr + AW'(1);
            if (r_p == r_planes) begin
               r_p <= '0;
               r_c <= r_c + LW'(1);
            end else begin
               r_p <= r_p + PW'(1);
            end
         end
         if (w_finish) begin
            r_res      <= w_accNext;
            r_resValid <= 1'b1;
`ifdef VVP_SEQ_CTRL_SAT_EN
            r_resOvf   <= w_ovfNext;
`endif
         end
         if (r_state == S_DONE && r_resValid && res_ready) begin
            r_resValid <= 1'b0;
            r_busy     <= 1'b0;
         end
      end
   end

   assign busy      = r_busy;
   assign mem_re    = w_issue;
   assign mem_addr  = w_issue ? r_addr : '0;
   assign vvp_mode  = r_mode;
   assign res       = r_res;
   assign res_valid = r_resValid;

endmodule

// File: tb/tb_vvp_seq_ctrl.sv
// tb_vvp_seq_ctrl: directed scoreboard bench for vvp_seq_ctrl (dut0: RDLAT=1/VVP_LAT=0, dut1: VVP_LAT=3).
module tb_vvp_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int fails  = 0;

   logic signed [7:0] sval [1024];

   // dut0 signals
   logic               start0 = 1'b0, res_ready0 = 1'b0;
   logic [1:0]         mode0 = '0;
   logic [9:0]         base0 = '0;
   logic [7:0]         len0 = '0;
   logic [2:0]         planes0 = '0;
   logic               busy0, mem_re0, res_valid0;
   logic [9:0]         mem_addr0;
   logic [1:0]         vvp_mode0;
   logic signed [7:0]  vvpS0;
   logic signed [31:0] res0;
`ifdef VVP_SEQ_CTRL_SAT_EN
   logic               res_ovf0, res_ovf1;
`endif

   // dut1 signals
   logic               start1 = 1'b0, res_ready1 = 1'b0;
   logic [9:0]         base1 = '0;
   logic [7:0]         len1 = '0;
   logic               busy1, mem_re1, res_valid1;
   logic [9:0]         mem_addr1;
   logic [1:0]         vvp_mode1;
   logic signed [7:0]  vvpS1;
   logic signed [31:0] res1;

   vvp_seq_ctrl dut0 (
      .clk(clk), .rst(rst), .start(start0), .cfg_mode(mode0), .cfg_base(base0),
      .cfg_len(len0), .cfg_planes(planes0), .busy(busy0), .mem_re(mem_re0),
      .mem_addr(mem_addr0), .vvp_mode(vvp_mode0), .vvp_S(vvpS0), .res(res0),
      .res_valid(res_valid0),
`ifdef VVP_SEQ_CTRL_SAT_EN
      .res_ovf(res_ovf0),
`endif
      .res_ready(res_ready0)
   );

   vvp_seq_ctrl #(.VVP_LAT(3)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .cfg_mode(2'd1), .cfg_base(base1),
      .cfg_len(len1), .cfg_planes(3'd0), .busy(busy1), .mem_re(mem_re1),
      .mem_addr(mem_addr1), .vvp_mode(vvp_mode1), .vvp_S(vvpS1), .res(res1),
      .res_valid(res_valid1),
`ifdef VVP_SEQ_CTRL_SAT_EN
      .res_ovf(res_ovf1),
`endif
      .res_ready(res_ready1)
   );

   // Memory + vvp model for dut0: one read cycle, combinational vvp.
   logic       m0V = 1'b0;
   logic [9:0] m0A = '0;
   always @(posedge clk) begin
      m0V <= mem_re0;
      m0A <= mem_addr0;
   end
   assign vvpS0 = m0V ? sval[m0A] : 8'sd0;

   // Memory + vvp model for dut1: four cycles total.
   logic [3:0] m1V = '0;
   logic [9:0] m1A [4];
   always @(posedge clk) begin
      m1V    <= {m1V[2:0], mem_re1};
      m1A[0] <= mem_addr1;
      for (int i = 1; i < 4; i++) m1A[i] <= m1A[i-1];
   end
   assign vvpS1 = m1V[3] ? sval[m1A[3]] : 8'sd0;

   int                 expAddr [$];
   logic signed [31:0] expRes  [$];
   int lastIssue0 = 0, lastIssue1 = 0, issues1 = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   // Address scoreboard: each issue from dut0 pops the next expected address.
   always @(negedge clk) begin
      if (mem_re0) begin
         lastIssue0 = cyc;
         if (expAddr.size() == 0) checkOutput("unexpected_issue", 32'(mem_addr0), 32'hFFFF_FFFF);
         else                     checkOutput("mem_addr", 32'(mem_addr0), 32'(expAddr.pop_front()));
      end
      if (mem_re1) begin
         lastIssue1 = cyc;
         issues1++;
      end
   end

   // Push expected addresses/result for a dut0 job, then pulse start.
   task automatic applyStimulus(input int base, input int len, input int planes, input int mode,
                                input logic extraStart);
      logic signed [31:0] acc;
      int a;
      acc = 0;
      for (int c = 0; c <= len; c++)
         for (int p = 0; p <= planes; p++) begin
            a = (base + c * (planes + 1) + p) % 1024;
            expAddr.push_back(a);
            acc = acc + (32'(sval[a]) <<< p);
         end
      expRes.push_back(acc);
      @(negedge clk);
      base0   = 10'(base);
      len0    = 8'(len);
      planes0 = 3'(planes);
      mode0   = 2'(mode);
      start0  = 1'b1;
      @(negedge clk);
      start0  = extraStart;
   endtask

   task automatic waitResult0(input string tag, input int expLat);
      int n = 0;
      logic signed [31:0] e;
      while (res_valid0 !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         checkOutput({tag, "_latency"}, 32'(cyc - lastIssue0), 32'(expLat));
         e = (expRes.size() > 0) ? expRes.pop_front() : 32'hDEAD_BEEF;
         checkOutput({tag, "_res"}, res0, e);
`ifdef VVP_SEQ_CTRL_SAT_EN
         checkOutput({tag, "_ovf"}, 32'(res_ovf0), 32'd0);
`endif
      end
   endtask

   task automatic acceptResult0(input string tag, input logic startToo);
      res_ready0 = 1'b1;
      start0     = startToo;
      @(posedge clk);
      #1;
      res_ready0 = 1'b0;
      start0     = 1'b0;
      checkOutput({tag, "_busy_after"}, 32'(busy0), 32'd0);
      checkOutput({tag, "_valid_after"}, 32'(res_valid0), 32'd0);
   endtask

   initial begin
      logic signed [31:0] held;
      int n;
      for (int i = 0; i < 1024; i++) sval[i] = 8'sd0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(busy0), 32'd0);
      checkOutput("rst_mem_re", 32'(mem_re0), 32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr0), 32'd0);
      checkOutput("rst_vvp_mode", 32'(vvp_mode0), 32'd0);
      checkOutput("rst_res", res0, 32'd0);
      checkOutput("rst_res_valid", 32'(res_valid0), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single issue
      sval[5] = -8'sd3;
      applyStimulus(5, 0, 0, 1, 1'b0);
      checkOutput("t1_busy", 32'(busy0), 32'd1);
      waitResult0("t1", 2);
      acceptResult0("t1", 1'b0);

      // Address/shift order
      for (int i = 0; i < 6; i++) sval[i] = 8'sd1;
      applyStimulus(0, 1, 2, 2, 1'b0);
      checkOutput("t2_vvp_mode", 32'(vvp_mode0), 32'd2);
      waitResult0("t2", 2);
      checkOutput("t2_mode_hold", 32'(vvp_mode0), 32'd2);
      acceptResult0("t2", 1'b0);

      // Pipelined vvp on dut1
      for (int i = 100; i < 104; i++) sval[i] = 8'sd64;
      issues1 = 0;
      @(negedge clk);
      base1  = 10'd100;
      len1   = 8'd3;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (res_valid1 !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t3_done", 32'(res_valid1), 32'd1);
      checkOutput("t3_latency", 32'(cyc - lastIssue1), 32'd5);
      checkOutput("t3_issues", 32'(issues1), 32'd4);
      checkOutput("t3_res", res1, 32'sd256);
      res_ready1 = 1'b1;
      @(negedge clk);
      res_ready1 = 1'b0;
      checkOutput("t3_busy_after", 32'(busy1), 32'd0);

      // Backpressure with ignored starts, including a start on the accept cycle
      sval[10] = 8'sd7;
      applyStimulus(10, 0, 0, 3, 1'b0);
      waitResult0("t4", 2);
      held = res0;
      for (int i = 0; i < 10; i++) begin
         start0 = (i % 2 == 0);
         @(negedge clk);
         checkOutput("t4_res_stable", res0, held);
         checkOutput("t4_valid_hold", 32'(res_valid0), 32'd1);
         checkOutput("t4_busy_hold", 32'(busy0), 32'd1);
      end
      acceptResult0("t4", 1'b1);
      repeat (2) @(negedge clk);
      checkOutput("t4_no_restart", 32'(busy0), 32'd0);
      sval[20] = 8'sd3;
      sval[21] = -8'sd2;
      applyStimulus(20, 0, 1, 0, 1'b0);
      waitResult0("t4b", 2);
      acceptResult0("t4b", 1'b0);

      // Async reset mid-ISSUE, then a clean job
      for (int i = 30; i < 38; i++) sval[i] = 8'sd9;
      applyStimulus(30, 3, 1, 1, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;
      expAddr.delete();
      expRes.delete();
      #1;
      checkOutput("t5_mem_re", 32'(mem_re0), 32'd0);
      checkOutput("t5_mem_addr", 32'(mem_addr0), 32'd0);
      checkOutput("t5_busy", 32'(busy0), 32'd0);
      checkOutput("t5_vvp_mode", 32'(vvp_mode0), 32'd0);
      checkOutput("t5_res", res0, 32'd0);
      checkOutput("t5_res_valid", 32'(res_valid0), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sval[40] = 8'sd2;
      sval[41] = -8'sd1;
      sval[42] = 8'sd5;
      sval[43] = 8'sd4;
      applyStimulus(40, 1, 1, 2, 1'b0);
      waitResult0("t5b", 2);
      checkOutput("t5b_model", res0, 32'sd13);
      acceptResult0("t5b", 1'b0);

      // Address wrap at 2^AW
      sval[1022] = 8'sd1;
      sval[1023] = 8'sd2;
      sval[0]    = 8'sd3;
      sval[1]    = 8'sd4;
      applyStimulus(1022, 3, 0, 0, 1'b0);
      waitResult0("t6", 2);
      checkOutput("t6_model", res0, 32'sd10);
      acceptResult0("t6", 1'b0);

      @(negedge clk);
      checkOutput("end_addr_queue", 32'(expAddr.size()), 32'd0);
      $display("[TB] directed sequence complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
